// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and drives all datapath selects. Memory accesses wait on mem_ready and are
// abandoned after MEM_TIMEOUT wait cycles, which raises the sticky err flag.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       err,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  // Last wait cycle index before the access is abandoned.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_JAL      = 4'd13
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q, err_set;
  logic             mem_wait, tmo_hit;
  logic             pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;

  // A wait cycle is any cycle in a memory state without mem_ready.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                    && !mem_ready;
  assign tmo_hit  = mem_wait && (tmo_cnt == TMO_LAST);

  // State register, sticky error flag and memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      err_q   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (err_set) err_q <= 1'b1;
      // Clearing on every state change (and on a timeout re-entering FETCH)
      // gives each memory state a fresh budget on entry.
      if ((state_d != state_q) || tmo_hit) tmo_cnt <= '0;
      else if (mem_wait)                   tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d     = state_q;
    err_set     = 1'b0;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    pc_src      = 2'd0;
    i_or_d      = 1'b0;
    reg_dst     = 2'd0;
    mem_to_reg  = 2'd0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_op      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          alu_src_b  = 2'd1;
          state_d    = S_DECODE;
        end else if (tmo_hit) begin
          // PC untouched, so the retry fetches the same address.
          err_set = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BNE:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          OP_ADDI, OP_XORI: state_d = S_EXEC_I;
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_SLT: state_d = S_EXEC_R;
              FN_JR:                  state_d = S_JR;
              default: begin
                err_set = 1'b1;
                state_d = S_FETCH;
              end
            endcase
          end
          default: begin
            err_set = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'd1;
        pc_write_c = !zero;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'd3;
        pc_write_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        pc_src     = 2'd2;
        pc_write_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from fetch, so it is the link value.
        pc_src      = 2'd3;
        pc_write_c  = 1'b1;
        reg_write_c = 1'b1;
        reg_dst     = 2'd2;
        mem_to_reg  = 2'd2;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read_c = 1'b1;
        i_or_d     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (tmo_hit) begin
          err_set = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM_WB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 2'd1;
        state_d     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_c = 1'b1;
        i_or_d      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (tmo_hit) begin
          err_set = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
        state_d = S_WB_R;
      end
      S_WB_R: begin
        reg_write_c = 1'b1;
        reg_dst     = 2'd1;
        state_d     = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are forced low for the whole reset pulse, not just after it.
  assign pc_write  = pc_write_c  & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign mem_read  = mem_read_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign err       = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm: per-instruction transaction model
// (cycle budget, strobe counts, select values) driven with random waits.
module tb_multicycle_control_fsm;

  localparam int MEM_TO = 4;

  localparam int C_ILL = 0, C_LW = 1, C_SW = 2, C_J = 3, C_JR = 4, C_JAL = 5, C_BNE = 6,
                 C_ADDI = 7, C_XORI = 8, C_ADD = 9, C_SUB = 10, C_SLT = 11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a, err;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  int   n_cmp = 0;
  int   n_mis = 0;
  logic exp_err;
  logic [3:0] fetch_state;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(MEM_TO), .TMO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .err(err), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h05: return C_BNE;
      6'h08: return C_ADDI;
      6'h0E: return C_XORI;
      6'h00: begin
        case (fn)
          6'h20:   return C_ADD;
          6'h22:   return C_SUB;
          6'h2A:   return C_SLT;
          6'h08:   return C_JR;
          default: return C_ILL;
        endcase
      end
      default: return C_ILL;
    endcase
  endfunction

  // Runs one instruction from FETCH: wf fetch wait cycles, wm data wait cycles.
  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic zv, input int wf, input int wm);
    int cls, mlen, n, ms, ex_c;
    bit is_mem, to, is_jb, is_ri, exp_rw;
    int ir_cnt, ir_cyc, pc_cnt, pc_first, pc_last, rw_cnt, rw_cyc, rw_dst, rw_m2r;
    int mr_cnt, mw_cnt, ad_cnt, exp_pc_cnt, exp_pc_last, exp_dst, exp_m2r;
    logic [5:0] alu_c [64];
    logic [5:0] ex_v;
    cls    = classify(op, fn);
    is_mem = (cls == C_LW) || (cls == C_SW);
    to     = is_mem && (wm >= MEM_TO);
    mlen   = to ? MEM_TO : wm + 1;
    is_jb  = (cls == C_J) || (cls == C_JR) || (cls == C_JAL) || (cls == C_BNE);
    is_ri  = (cls >= C_ADDI);
    ms     = wf + 4;
    n      = wf + 2;
    if (is_mem)     n += 1 + mlen + ((cls == C_LW && !to) ? 1 : 0);
    else if (is_jb) n += 1;
    else if (is_ri) n += 2;
    ir_cnt = 0; ir_cyc = 0; pc_cnt = 0; pc_first = -1; pc_last = -1;
    rw_cnt = 0; rw_cyc = 0; rw_dst = -1; rw_m2r = -1; mr_cnt = 0; mw_cnt = 0; ad_cnt = 0;
    for (int c = 1; c <= n; c++) begin
      opcode = op;
      funct  = fn;
      if (c <= wf)                              mem_ready = 1'b0;
      else if (c == wf + 1)                     mem_ready = 1'b1;
      else if (is_mem && c >= ms && c < ms + mlen) mem_ready = ((c - ms) >= wm);
      else                                      mem_ready = 1'($urandom_range(0, 1));
      zero = (cls == C_BNE && c == n) ? zv : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ir_write)  begin ir_cnt++; ir_cyc = c; end
      if (pc_write)  begin pc_cnt++; if (pc_first < 0) pc_first = int'(pc_src); pc_last = int'(pc_src); end
      if (reg_write) begin rw_cnt++; rw_cyc = c; rw_dst = int'(reg_dst); rw_m2r = int'(mem_to_reg); end
      if (mem_read)  mr_cnt++;
      if (mem_write) mw_cnt++;
      if ((mem_read || mem_write) && i_or_d) ad_cnt++;
      alu_c[c] = {alu_op, alu_src_a, alu_src_b};
      @(posedge clk); #1;
    end
    // Expected transaction summary
    exp_pc_cnt  = 1;
    exp_pc_last = 0;
    case (cls)
      C_J, C_JAL: begin exp_pc_cnt = 2; exp_pc_last = 3; end
      C_JR:       begin exp_pc_cnt = 2; exp_pc_last = 2; end
      C_BNE:      if (!zv) begin exp_pc_cnt = 2; exp_pc_last = 1; end
      default:    ;
    endcase
    exp_rw  = (cls == C_LW && !to) || (cls == C_JAL) || is_ri;
    exp_dst = (cls == C_JAL) ? 2 : ((cls >= C_ADD) ? 1 : 0);
    exp_m2r = (cls == C_JAL) ? 2 : ((cls == C_LW) ? 1 : 0);
    ex_c = 0;
    ex_v = '0;
    case (cls)
      C_ADD:       begin ex_c = n - 1;  ex_v = {3'd0, 1'b1, 2'd0}; end
      C_SUB:       begin ex_c = n - 1;  ex_v = {3'd1, 1'b1, 2'd0}; end
      C_SLT:       begin ex_c = n - 1;  ex_v = {3'd3, 1'b1, 2'd0}; end
      C_ADDI:      begin ex_c = n - 1;  ex_v = {3'd0, 1'b1, 2'd2}; end
      C_XORI:      begin ex_c = n - 1;  ex_v = {3'd2, 1'b1, 2'd2}; end
      C_BNE:       begin ex_c = n;      ex_v = {3'd1, 1'b1, 2'd0}; end
      C_LW, C_SW:  begin ex_c = wf + 3; ex_v = {3'd0, 1'b1, 2'd2}; end
      default:     ex_c = 0;
    endcase
    chk({nm, ".ir_cnt"}, 32'(ir_cnt), 32'(1));
    chk({nm, ".ir_cyc"}, 32'(ir_cyc), 32'(wf + 1));
    chk({nm, ".pc_cnt"}, 32'(pc_cnt), 32'(exp_pc_cnt));
    chk({nm, ".pc_src_fetch"}, 32'(pc_first), 32'(0));
    chk({nm, ".pc_src_last"}, 32'(pc_last), 32'(exp_pc_last));
    chk({nm, ".rw_cnt"}, 32'(rw_cnt), 32'(exp_rw ? 1 : 0));
    if (exp_rw) begin
      chk({nm, ".rw_cyc"}, 32'(rw_cyc), 32'(n));
      chk({nm, ".reg_dst"}, 32'(rw_dst), 32'(exp_dst));
      chk({nm, ".mem_to_reg"}, 32'(rw_m2r), 32'(exp_m2r));
    end
    chk({nm, ".mr_cnt"}, 32'(mr_cnt), 32'(wf + 1 + ((cls == C_LW) ? mlen : 0)));
    chk({nm, ".mw_cnt"}, 32'(mw_cnt), 32'((cls == C_SW) ? mlen : 0));
    chk({nm, ".addr_cnt"}, 32'(ad_cnt), 32'(is_mem ? mlen : 0));
    chk({nm, ".alu_fetch"}, 32'(alu_c[wf + 1]), 32'({3'd0, 1'b0, 2'd1}));
    chk({nm, ".alu_decode"}, 32'(alu_c[wf + 2]), 32'({3'd0, 1'b0, 2'd3}));
    if (ex_c != 0) chk({nm, ".alu_exec"}, 32'(alu_c[ex_c]), 32'(ex_v));
    if (cls == C_ILL || to) exp_err = 1'b1;
    // Back in FETCH after exactly n cycles
    mem_ready = 1'b0;
    #1;
    chk({nm, ".next_fetch"}, 32'({mem_read, i_or_d, ir_write, pc_write}), 32'(4'b1000));
    chk({nm, ".err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_err = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int pick, wf, wm;
    logic [5:0] op, fn;
    int ir_cnt, pc_cnt;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = '0; funct = '0; zero = 1'b0; exp_err = 1'b0;

    // Strobes held low during reset even with mem_ready high in FETCH
    #2;
    chk("rst.strobes", 32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'(0));
    chk("rst.err", 32'(err), 32'(0));
    fetch_state = state;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.fetch_sig", 32'({mem_read, i_or_d, ir_write, pc_write}), 32'(4'b1000));
    @(posedge clk); #1;

    // Reset while MEM_WR is waiting on mem_ready
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wr.pre_mem_write", 32'({mem_write, i_or_d}), 32'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("rst_wr.mem_write", 32'(mem_write), 32'(0));
    chk("rst_wr.err", 32'(err), 32'(0));
    chk("rst_wr.state", 32'(state), 32'(fetch_state));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_wr.fetch_sig", 32'({mem_read, i_or_d, mem_write}), 32'(3'b100));
    @(posedge clk); #1;

    // Directed instructions
    run_instr("add",  6'h00, 6'h20, 1'b0, 0, 0);
    run_instr("bne0", 6'h05, 6'h11, 1'b0, 0, 0);
    run_instr("bne1", 6'h05, 6'h11, 1'b1, 0, 0);
    run_instr("jal",  6'h03, 6'h00, 1'b0, 0, 0);
    run_instr("jr",   6'h00, 6'h08, 1'b0, 0, 0);
    run_instr("lw_w2", 6'h23, 6'h00, 1'b0, 0, 2);

    // Random legal instructions with random wait states
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(1, 11);
      fn   = 6'($urandom_range(0, 63));
      case (pick)
        C_LW:    op = 6'h23;
        C_SW:    op = 6'h2B;
        C_J:     op = 6'h02;
        C_JR:    begin op = 6'h00; fn = 6'h08; end
        C_JAL:   op = 6'h03;
        C_BNE:   op = 6'h05;
        C_ADDI:  op = 6'h08;
        C_XORI:  op = 6'h0E;
        C_ADD:   begin op = 6'h00; fn = 6'h20; end
        C_SUB:   begin op = 6'h00; fn = 6'h22; end
        default: begin op = 6'h00; fn = 6'h2A; end
      endcase
      wf = $urandom_range(0, 2);
      wm = $urandom_range(0, 2);
      run_instr("rnd", op, fn, 1'($urandom_range(0, 1)), wf, wm);
    end

    // Fetch timeout: MEM_TO wait cycles without mem_ready
    ir_cnt = 0;
    pc_cnt = 0;
    for (int c = 1; c <= MEM_TO; c++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      if (ir_write) ir_cnt++;
      if (pc_write) pc_cnt++;
      @(posedge clk); #1;
      if (c == MEM_TO - 1) chk("fto.err_early", 32'(err), 32'(0));
    end
    chk("fto.err", 32'(err), 32'(1));
    chk("fto.strobes", 32'(ir_cnt + pc_cnt), 32'(0));
    chk("fto.fetch_sig", 32'({mem_read, i_or_d}), 32'(2'b10));
    exp_err = 1'b1;
    run_instr("fto_retry", 6'h00, 6'h22, 1'b0, 1, 0);

    // Illegal instructions and data-phase timeouts, each from a clean reset
    do_reset();
    chk("rst2.err", 32'(err), 32'(0));
    run_instr("ill_op", 6'h3F, 6'h00, 1'b0, 0, 0);
    do_reset();
    run_instr("ill_fn", 6'h00, 6'h15, 1'b0, 0, 0);
    do_reset();
    run_instr("lw_to", 6'h23, 6'h00, 1'b0, 0, MEM_TO);
    do_reset();
    run_instr("sw_to", 6'h2B, 6'h00, 1'b0, 1, MEM_TO + 1);
    run_instr("post_to_xori", 6'h0E, 6'h00, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
